// File: rtl/vec_mem_arbiter_if.sv
// vec_mem_arbiter_if: load/store requester handshakes and memory-queue bus of the arbiter
interface vec_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_BITS   = 9
);
    localparam int DW_B = DATA_WIDTH / 8;
    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [LEN_BITS-1:0]   ld_len;
    logic                  ld_gnt;
    logic                  ld_done;
    logic                  st_req;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [LEN_BITS-1:0]   st_len;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DW_B-1:0]       st_be;
    logic                  st_data_valid;
    logic                  st_data_ready;
    logic                  st_gnt;
    logic                  st_done;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic                  q_req;
    logic [DATA_WIDTH-1:0] q_wdata;
    logic [DW_B-1:0]       q_be;
    logic                  q_wvalid;
    logic                  q_wstart;
    logic                  q_done_ld;
    logic                  q_done_st;
    modport master (
        input  ld_req, ld_addr, ld_len, st_req, st_addr, st_len, st_data, st_be, st_data_valid,
               q_done_ld, q_done_st,
        output ld_gnt, ld_done, st_data_ready, st_gnt, st_done,
               q_addr, q_req, q_wdata, q_be, q_wvalid, q_wstart
    );
    modport slave (
        output ld_req, ld_addr, ld_len, st_req, st_addr, st_len, st_data, st_be, st_data_valid,
               q_done_ld, q_done_st,
        input  ld_gnt, ld_done, st_data_ready, st_gnt, st_done,
               q_addr, q_req, q_wdata, q_be, q_wvalid, q_wstart
    );
endinterface

// File: rtl/vec_mem_arbiter.sv
// vec_mem_arbiter: grants one load or store burst at a time onto the memory queue, with a completion watchdog
module vec_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_BITS   = 9,
    parameter int WD_BITS    = 12
) (
    input  logic              clk,
    input  logic              rst,
    vec_mem_arbiter_if.master bus,
    output logic              err
);
    localparam int DW_B = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DW_B);
    localparam logic [WD_BITS-1:0] WD_MAX = '1;

    typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  last_st_q, last_st_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [LEN_BITS-1:0]   cnt_q, cnt_d;
    logic [WD_BITS-1:0]    wd_q, wd_d;
    logic                  ld_gnt_q, ld_gnt_d;
    logic                  st_gnt_q, st_gnt_d;
    logic                  ld_done_q, ld_done_d;
    logic                  st_done_q, st_done_d;
    logic                  err_q, err_d;
    logic                  q_req, q_wvalid, last_beat, pick_st;

    // On a tie the requester that was not served last wins
    assign pick_st   = bus.st_req && (!bus.ld_req || !last_st_q);
    assign q_req     = state_q == LD_ISSUE && len_q != '0;
    assign q_wvalid  = state_q == ST_ISSUE && len_q != '0 && bus.st_data_valid;
    assign last_beat = cnt_q + 1'b1 == len_q;

    assign bus.ld_gnt        = ld_gnt_q;
    assign bus.st_gnt        = st_gnt_q;
    assign bus.ld_done       = ld_done_q;
    assign bus.st_done       = st_done_q;
    assign bus.st_data_ready = state_q == ST_ISSUE && len_q != '0;
    assign bus.q_req         = q_req;
    assign bus.q_wvalid      = q_wvalid;
    assign bus.q_wstart      = q_wvalid && cnt_q == '0;
    assign bus.q_addr        = (q_req || q_wvalid) ? addr_q : '0;
    assign bus.q_wdata       = q_wvalid ? bus.st_data : '0;
    assign bus.q_be          = q_wvalid ? bus.st_be : '0;
    assign err               = err_q;

    always_comb begin
        state_d   = state_q;
        last_st_d = last_st_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q + 1'b1;
        err_d     = err_q;
        ld_gnt_d  = 1'b0;
        st_gnt_d  = 1'b0;
        ld_done_d = 1'b0;
        st_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ld_req || bus.st_req) begin
                    state_d  = pick_st ? ST_ISSUE : LD_ISSUE;
                    addr_d   = pick_st ? bus.st_addr : bus.ld_addr;
                    len_d    = pick_st ? bus.st_len : bus.ld_len;
                    cnt_d    = '0;
                    ld_gnt_d = !pick_st;
                    st_gnt_d = pick_st;
                end
            end
            LD_ISSUE, ST_ISSUE: begin
                if (len_q == '0) begin
                    state_d   = IDLE;
                    ld_done_d = state_q == LD_ISSUE;
                    st_done_d = state_q == ST_ISSUE;
                    last_st_d = state_q == ST_ISSUE;
                end else if (q_req || q_wvalid) begin
                    addr_d = addr_q + STEP;
                    cnt_d  = cnt_q + 1'b1;
                    wd_d   = '0;
                    if (last_beat) state_d = state_q == LD_ISSUE ? LD_WAIT : ST_WAIT;
                end
            end
            LD_WAIT, ST_WAIT: begin
                if (state_q == LD_WAIT ? bus.q_done_ld : bus.q_done_st) begin
                    state_d   = IDLE;
                    ld_done_d = state_q == LD_WAIT;
                    st_done_d = state_q == ST_WAIT;
                    last_st_d = state_q == ST_WAIT;
                end else if (wd_d == WD_MAX) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    last_st_d = state_q == ST_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_st_q <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            ld_gnt_q  <= 1'b0;
            st_gnt_q  <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_st_q <= last_st_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            ld_gnt_q  <= ld_gnt_d;
            st_gnt_q  <= st_gnt_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
        end
    end
endmodule

// File: tb/tb_vec_mem_arbiter.sv
// tb_vec_mem_arbiter: directed and randomized bursts checked against burst-level expectations
module tb_vec_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LB = 9;
    localparam int WB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    int   checks = 0;
    int   errors = 0;

    vec_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_BITS(LB)) bus ();
    vec_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_BITS(LB), .WD_BITS(WB)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_ctl"}, {bus.ld_gnt, bus.st_gnt, bus.ld_done, bus.st_done,
                            bus.q_req, bus.q_wvalid, bus.q_wstart, bus.st_data_ready}, 0);
        chk({tag, "_data"}, {bus.q_addr, bus.q_be}, 0);
        chk({tag, "_wdata"}, bus.q_wdata, 0);
    endtask

    // Load burst: beat i must address base + 8*i (32-bit wrap); done follows q_done_ld by one cycle
    task automatic run_ld(input logic [31:0] base, input logic [8:0] len, input int dly);
        logic [31:0] a;
        nxt(); bus.ld_req = 1'b1; bus.ld_addr = base; bus.ld_len = len; settle();
        chk("ld_pre_gnt", bus.ld_gnt, 0);
        nxt(); bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_len = '0; settle();
        chk("ld_gnt", {bus.ld_gnt, bus.st_gnt}, 2'b10);
        for (int i = 0; i < int'(len); i++) begin
            if (i > 0) begin
                nxt(); settle();
                chk("ld_gnt_pulse", bus.ld_gnt, 0);
            end
            a = base + 32'(i * 8);
            chk("ld_q_req", {bus.q_req, bus.q_wvalid}, 2'b10);
            chk("ld_q_addr", bus.q_addr, a);
        end
        if (len == 0) chk("ld_len0_q", {bus.q_req, bus.q_addr}, 0);
        else for (int k = 0; k <= dly; k++) begin
            nxt(); bus.q_done_ld = k == dly; bus.q_done_st = 1'($urandom_range(0, 1)); settle();
            chk("ld_wait", {bus.ld_done, bus.q_req, bus.q_addr}, 0);
        end
        nxt(); bus.q_done_ld = 1'b0; bus.q_done_st = 1'b0; settle();
        chk("ld_done", {bus.ld_done, bus.st_done, bus.q_req}, 3'b100);
        nxt(); settle();
        chk("ld_done_pulse", {bus.ld_done, bus.ld_gnt}, 0);
    endtask

    // Store burst: vpat[k] gives st_data_valid on issue cycle k (valid forced high after 16 cycles)
    task automatic run_st(input logic [31:0] base, input logic [8:0] len, input logic [15:0] vpat, input int dly);
        logic [63:0] d;
        logic [7:0]  be;
        logic        v;
        logic        acc;
        int          i;
        i = 0;
        nxt(); bus.st_req = 1'b1; bus.st_addr = base; bus.st_len = len; settle();
        chk("st_pre_gnt", {bus.st_gnt, bus.st_data_ready}, 0);
        for (int k = 0; k < 64 && (k == 0 || i < int'(len)); k++) begin
            nxt();
            v = k < 16 ? vpat[k[3:0]] : 1'b1;
            d = {$urandom, $urandom};
            be = 8'($urandom);
            bus.st_req = 1'b0; bus.st_addr = '0;
            bus.st_data_valid = v; bus.st_data = d; bus.st_be = be;
            settle();
            acc = v && len != 0;
            chk("st_gnt", {bus.st_gnt, bus.ld_gnt}, {k == 0, 1'b0});
            chk("st_ready", bus.st_data_ready, len != 0);
            chk("st_wvalid", {bus.q_wvalid, bus.q_wstart, bus.q_req}, {acc, acc && i == 0, 1'b0});
            chk("st_q_addr", bus.q_addr, acc ? base + 32'(i * 8) : 32'h0);
            chk("st_q_wdata", bus.q_wdata, acc ? d : 64'h0);
            chk("st_q_be", bus.q_be, acc ? be : 8'h0);
            if (acc) i++;
        end
        chk("st_beats", i, len);
        if (len != 0) for (int k = 0; k <= dly; k++) begin
            nxt(); bus.st_data_valid = 1'b0; bus.q_done_st = k == dly;
            bus.q_done_ld = 1'($urandom_range(0, 1)); settle();
            chk("st_wait", {bus.st_done, bus.q_wvalid, bus.st_data_ready, bus.q_addr}, 0);
        end
        nxt(); bus.st_data_valid = 1'b0; bus.q_done_st = 1'b0; bus.q_done_ld = 1'b0; settle();
        chk("st_done", {bus.st_done, bus.ld_done, bus.q_wvalid}, 3'b100);
        nxt(); settle();
        chk("st_done_pulse", {bus.st_done, bus.st_gnt}, 0);
    endtask

    initial begin
        bus.ld_req = 1'b1; bus.ld_addr = 32'h100; bus.ld_len = 9'd1;
        bus.st_req = 1'b1; bus.st_addr = 32'h200; bus.st_len = 9'd1;
        bus.st_data = 64'hDEAD_BEEF_0000_0001; bus.st_be = 8'hFF; bus.st_data_valid = 1'b1;
        bus.q_done_ld = 1'b0; bus.q_done_st = 1'b0;
        repeat (2) @(posedge clk);
        #5;
        idle_outs("reset");
        chk("reset_err", err, 0);
        // both requesters high straight out of reset: load wins, store follows its done
        nxt(); rst = 1'b0; bus.st_data_valid = 1'b0; settle();
        idle_outs("release");
        nxt(); settle();
        chk("tie_ld_gnt", {bus.ld_gnt, bus.st_gnt, bus.q_req}, 3'b101);
        chk("tie_ld_addr", bus.q_addr, 32'h100);
        nxt(); bus.q_done_ld = 1'b1; settle();
        chk("tie_ld_wait", {bus.ld_done, bus.st_gnt, bus.q_req}, 0);
        nxt(); bus.q_done_ld = 1'b0; settle();
        chk("tie_ld_done", {bus.ld_done, bus.st_gnt}, 2'b10);
        nxt(); bus.st_data_valid = 1'b1; bus.st_data = 64'hA5; bus.st_be = 8'h0F; settle();
        chk("tie_st_gnt", {bus.st_gnt, bus.ld_gnt, bus.q_wvalid, bus.q_wstart}, 4'b1011);
        chk("tie_st_beat", {bus.q_addr, bus.q_be, bus.q_wdata[7:0]}, {32'h200, 8'h0F, 8'hA5});
        bus.ld_len = '0; bus.st_len = '0;
        nxt(); bus.st_data_valid = 1'b0; bus.q_done_st = 1'b1; settle();
        chk("tie_st_wait", {bus.st_done, bus.ld_gnt}, 0);
        nxt(); bus.q_done_st = 1'b0; settle();
        chk("tie_st_done", {bus.st_done, bus.ld_gnt}, 2'b10);
        nxt(); settle();
        chk("tie2_ld_gnt", {bus.ld_gnt, bus.st_gnt, bus.q_req}, 3'b100);
        nxt(); settle();
        chk("tie2_ld_done", {bus.ld_done, bus.st_done}, 2'b10);
        nxt(); settle();
        chk("tie2_st_gnt", {bus.ld_gnt, bus.st_gnt, bus.q_wvalid}, 3'b010);
        nxt(); bus.ld_req = 1'b0; bus.st_req = 1'b0; settle();
        chk("tie2_st_done", {bus.ld_done, bus.st_done}, 2'b01);
        nxt(); settle();
        idle_outs("tie_end");
        run_ld(32'h1000, 9'd3, 2);
        run_ld(32'hFFFF_FFF8, 9'd2, 1);
        run_st(32'h6000, 9'd2, 16'b101, 1);
        run_ld(32'h7000, 9'd0, 0);
        run_st(32'h7100, 9'd0, 16'hFFFF, 0);
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1)
                run_ld($urandom, 9'($urandom_range(0, 6)), $urandom_range(0, 8));
            else
                run_st($urandom, 9'($urandom_range(0, 6)), 16'($urandom), $urandom_range(0, 8));
        end
        // watchdog: load burst whose completion never arrives
        nxt(); bus.ld_req = 1'b1; bus.ld_addr = 32'h2000; bus.ld_len = 9'd1; settle();
        nxt(); bus.ld_req = 1'b0; settle();
        chk("wd_gnt", {bus.ld_gnt, bus.q_req}, 2'b11);
        for (int k = 0; k < 15; k++) begin
            nxt(); bus.q_done_st = 1'b1; settle();
            chk("wd_wait", {err, bus.ld_done}, 0);
        end
        nxt(); bus.q_done_st = 1'b0; settle();
        chk("wd_err", {err, bus.ld_done, bus.q_req}, 3'b100);
        nxt(); settle();
        chk("wd_no_done", {err, bus.ld_done, bus.st_done}, 3'b100);
        run_ld(32'h3000, 9'd2, 0);
        chk("err_sticky", err, 1);
        // asynchronous reset during store beat 1
        nxt(); bus.st_req = 1'b1; bus.st_addr = 32'h4000; bus.st_len = 9'd4; settle();
        nxt(); bus.st_req = 1'b0; bus.st_data_valid = 1'b1; bus.st_data = 64'h1111; bus.st_be = 8'hFF; settle();
        chk("rst_beat0", {bus.st_gnt, bus.q_wvalid, bus.q_wstart}, 3'b111);
        nxt(); bus.st_data = 64'h2222; settle();
        chk("rst_beat1", {bus.q_wvalid, bus.q_addr}, {1'b1, 32'h4008});
        rst = 1'b1;
        #1;
        idle_outs("rst_async");
        chk("rst_err", err, 0);
        nxt(); rst = 1'b0; bus.st_data_valid = 1'b0; bus.q_done_st = 1'b1; settle();
        idle_outs("rst_release");
        nxt(); bus.q_done_st = 1'b0; settle();
        idle_outs("rst_after");
        run_st(32'h5000, 9'd1, 16'h1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
